// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and byte-enable helper for the memory responder
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ_WAIT = 3'd1,
        ST_WRITE     = 3'd2,
        ST_RESP      = 3'd3
    } state_e;

    // Byte enables for a naturally aligned access; illegal sizes enable nothing.
    function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b0001 << lo;
            MEM_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            MEM_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage with byte-enabled synchronous write and synchronous full-word read
module mem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding fetch/load/store responder with fixed read latency
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic [2:0]  state_o
);

    localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            lane_q, lane_d;
    logic [ADDR_WIDTH-1:0] widx_q, widx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  req_err;
    logic [2:0]            cnt_inc;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_raddr;
    logic [31:0]           arr_rdata;
    logic [31:0]           lane_shift;
    logic [31:0]           load_data;

    assign req_ready_o = (state_q == ST_IDLE) && rst_ni;
    assign accept      = req_valid_i && req_ready_o;
    assign cnt_inc     = cnt_q + 3'd1;

    always_comb begin
        req_err = 1'b0;
        if (req_size_i == MEM_ILL)                             req_err = 1'b1;
        if (req_size_i == MEM_HALF && req_addr_i[0])           req_err = 1'b1;
        if (req_size_i == MEM_WORD && req_addr_i[1:0] != 2'b0) req_err = 1'b1;
        if (|req_addr_i[31:ADDR_WIDTH+2])                      req_err = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            write_q <= 1'b0;
            size_q  <= MEM_BYTE;
            lane_q  <= 2'd0;
            widx_q  <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    // Request fields are captured only on accept and then frozen until the next IDLE.
    always_comb begin
        write_d = write_q;
        size_d  = size_q;
        lane_d  = lane_q;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        if (accept) begin
            write_d = req_write_i;
            size_d  = req_size_i;
            lane_d  = req_addr_i[1:0];
            widx_d  = req_addr_i[ADDR_WIDTH+1:2];
            wdata_d = req_wdata_i << {req_addr_i[1:0], 3'b000};
            be_d    = be_from(req_size_i, req_addr_i[1:0]);
            err_d   = req_err;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = 3'd0;
                    if (req_err)                 state_d = ST_RESP;
                    else if (req_write_i)        state_d = ST_WRITE;
                    else if (READ_LATENCY == 1)  state_d = ST_RESP;
                    else                         state_d = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc == LAT_M1) state_d = ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // In IDLE the array reads the incoming address so a latency-1 load has data on the RESP cycle.
    assign arr_raddr = (state_q == ST_IDLE) ? req_addr_i[ADDR_WIDTH+1:2] : widx_q;
    assign arr_we    = (state_q == ST_WRITE);

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .be_i    (be_q),
        .waddr_i (widx_q),
        .wdata_i (wdata_q),
        .raddr_i (arr_raddr),
        .rdata_o (arr_rdata)
    );

    assign lane_shift = arr_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_data = 32'd0;
        case (size_q)
            MEM_BYTE: load_data = {24'd0, lane_shift[7:0]};
            MEM_HALF: load_data = {16'd0, lane_shift[15:0]};
            MEM_WORD: load_data = arr_rdata;
            default:  load_data = 32'd0;
        endcase
    end

    always_comb begin
        resp_valid_o = (state_q == ST_RESP);
        resp_error_o = resp_valid_o && err_q;
        resp_rdata_o = 32'd0;
        if (resp_valid_o && !err_q && !write_q) resp_rdata_o = load_data;
        state_o = state_q;
    end

endmodule
